// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_pkg
// Brief    : Shared types and constants for the MIPS CPU front end.
// Revision : 1.0
// ============================================================================
package mips_cpu_pkg;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;

endpackage : mips_cpu_pkg
`default_nettype wire

// File: rtl/mips_cpu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_fetch
// Brief    : Instruction fetch with PC, one branch delay slot and halt-on-jump-to-zero.
// Revision : 1.0
// ============================================================================
module mips_cpu_fetch
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] HALT_ADDRESS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        in_delay_slot,
    output logic        addr_error,
    output logic        active
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_pending;
    logic [31:0]  r_pending_target;
    logic         r_addr_error;

    fetch_state_t w_next_state;
    logic [31:0]  w_next_pc;
    logic         w_next_pending;
    logic [31:0]  w_next_target;
    logic         w_next_addr_error;
    logic [31:0]  w_pc_plus4;

    always_comb begin
        w_pc_plus4        = r_pc + 32'd4;
        w_next_state      = r_state;
        w_next_pc         = r_pc;
        w_next_pending    = r_pending;
        w_next_target     = r_pending_target;
        w_next_addr_error = 1'b0;

        // A branch seen while the delay slot is issuing is deliberately dropped.
        if (r_state == RUN && !stall) begin
            if (r_pending) begin
                w_next_pc      = r_pending_target;
                w_next_pending = 1'b0;
                if (r_pending_target == HALT_ADDRESS) begin
                    w_next_state = HALTED;
                end
            end else if (branch_taken) begin
                w_next_pc         = w_pc_plus4;
                w_next_pending    = 1'b1;
                w_next_target     = {branch_target[31:2], 2'b00};
                w_next_addr_error = (branch_target[1:0] != 2'b00);
            end else begin
                w_next_pc = w_pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= RUN;
            r_pc             <= RESET_VECTOR;
            r_pending        <= 1'b0;
            r_pending_target <= 32'h0000_0000;
            r_addr_error     <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_pc             <= w_next_pc;
            r_pending        <= w_next_pending;
            r_pending_target <= w_next_target;
            r_addr_error     <= w_next_addr_error;
        end
    end

    assign instr_address = r_pc;
    assign pc_out        = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign instr_out     = (r_state == RUN) ? instr_readdata : NOP_INSTR;
    assign in_delay_slot = r_pending;
    assign addr_error    = r_addr_error;
    assign active        = (r_state == RUN);

endmodule : mips_cpu_fetch
`default_nettype wire

// File: doc/mips_cpu_fetch.md
Name: mips_cpu_fetch

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction memory.
- Owns the program counter and drives instr_address. Presents the fetched word and its PC to decode.
- Implements MIPS branch-delay-slot sequencing: one delay slot, then redirect to the target.
- Detects the halt condition (jump to address 0) and deasserts active.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDRESS, 32'h00000000, a redirect to this address halts fetch once the delay slot has issued.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC and pending-branch state this cycle.
- branch_taken  input  1  decode resolved the instruction currently at pc_out as a taken branch/jump.
- branch_target  input  32  redirect address; valid when branch_taken=1.
- instr_address  output  32  fetch address to instruction memory; equals PC.
- instr_readdata  input  32  word returned combinationally by memory for instr_address.
- instr_out  output  32  instruction to decode; equals instr_readdata while RUN, 32'h0 (nop) while HALTED.
- pc_out  output  32  address of instr_out.
- pc_plus4  output  32  pc_out+4, for link register writes.
- in_delay_slot  output  1  instr_out is the delay-slot instruction of a taken branch.
- addr_error  output  1  one-cycle pulse: branch_target[1:0] != 0 was accepted.
- active  output  1  1 while RUN, 0 once HALTED.

Behaviour:
- State machine has two states, RUN and HALTED. Reset is asynchronous:
  - state=RUN, PC=RESET_VECTOR, pending=0, pending_target=0.
  - addr_error=0, active=1, in_delay_slot=0.
- Reset asserted mid-operation discards any pending branch immediately.
- Memory read is combinational, so fetch latency is 0 cycles: instr_out is valid in the same cycle as instr_address.
- PC update in RUN, evaluated each rising edge, highest priority first:
  - stall=1: PC, pending and pending_target hold; branch_taken and branch_target are ignored; addr_error=0.
  - pending=1 (current instruction is the delay slot):
    - PC <= pending_target; pending <= 0.
    - If pending_target == HALTED_ADDRESS check matches (pending_target == HALT_ADDRESS), state <= HALTED; PC is still loaded.
    - A branch_taken seen here (branch in a delay slot) is ignored: no new pending branch, addr_error=0.
  - branch_taken=1:
    - PC <= PC+4 (the delay slot); pending <= 1.
    - pending_target <= {branch_target[31:2],2'b00}.
    - addr_error <= (branch_target[1:0] != 0).
  - Otherwise: PC <= PC+4.
- in_delay_slot is combinational: equals pending.
- HALTED:
  - PC frozen; instr_address keeps its last value.
  - instr_out=0, active=0.
  - stall and branch_taken are ignored.
  - Only reset leaves HALTED.
- Arithmetic:
  - PC+4 is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.
  - A wrap to 0 reached by sequential increment does not halt; halt occurs only via a branch target.
- Simultaneous events:
  - stall with branch_taken: branch not accepted. Decode must re-present branch_taken on the unstalled cycle.
  - reset dominates everything.
- addr_error is registered and is 1 only in the cycle after acceptance.

Decomposition:
- Shared package mips_cpu_pkg holds:
  - fetch_state_t enum {RUN, HALTED};
  - constants RESET_VECTOR_DEFAULT = 32'hBFC00000 and NOP_INSTR = 32'h0.
- No sub-module is needed. A single module with one always_ff for state/PC/pending and one always_comb for outputs and next-PC is natural.

Test Plan:
- Reset, no branches, 4 cycles -> instr_address = BFC00000, BFC00004, BFC00008, BFC0000C; active=1; in_delay_slot=0.
- branch_taken=1, target=BFC00040 at PC=BFC00008 -> next PC=BFC0000C with in_delay_slot=1, then BFC00040, then BFC00044.
- JR to 0 at PC=BFC00010 -> delay slot BFC00014 issues, next edge active=0, instr_out=0; PC stays 0 for 10+ cycles regardless of branch_taken.
- stall=1 for 3 cycles during the delay slot (PC=BFC0000C, pending=1) -> PC holds BFC0000C; on release PC=target; a branch_taken asserted during the stall is ignored.
- branch_target=BFC00042 -> addr_error pulses for exactly one cycle; PC after the delay slot = BFC00040.
- Assert reset asynchronously (between edges) while pending=1 -> outputs immediately show PC=BFC00000, in_delay_slot=0; after release, sequential fetch resumes with no redirect.
